// File: rtl/rx_bit_sequencer_pkg.sv
// Shared types and limits for the serial receive sequencer.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package rx_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START_CHK,
        RECEIVE,
        STOP_CHK
    } rx_state_t;

    // Smallest timing values the sequencer can run with. Smaller requests
    // are raised to these when latched so the FSM can never stall.
    localparam int MIN_BIT_PERIOD = 4;
    localparam int MIN_DATA_BITS  = 1;

endpackage

// File: rtl/rx_bit_sequencer_if.sv
// Receive-sequencer bus: line and timing inputs plus status and strobe outputs.
// Latency: n/a (wiring only).
// Backpressure: none; strobes are single-cycle and must be consumed when seen.
//
// Signals:
//   serial_in     synchronized receive line, idle high
//   bit_period    clocks per bit (P)
//   data_bits     data bits per packet (D)
//   busy          sequencer is inside a packet
//   shift_strobe  one-cycle pulse: shift serial_in into the shift register
//   packet_done   one-cycle pulse: packet good, load the receive buffer
//   framing_error sticky: stop bit was sampled low
interface rx_bit_sequencer_if #(
    parameter int NUM_CNT_BITS = 4,
    parameter int BIT_CNT_BITS = 4
);
    logic                    serial_in;
    logic [NUM_CNT_BITS-1:0] bit_period;
    logic [BIT_CNT_BITS-1:0] data_bits;
    logic                    busy;
    logic                    shift_strobe;
    logic                    packet_done;
    logic                    framing_error;

    modport master (
        output serial_in, bit_period, data_bits,
        input  busy, shift_strobe, packet_done, framing_error
    );

    modport slave (
        input  serial_in, bit_period, data_bits,
        output busy, shift_strobe, packet_done, framing_error
    );
endinterface

// File: rtl/rx_bit_sequencer_flex_counter.sv
// Programmable up-counter: counts 1..rollover_val then wraps back to 1.
// Latency: count_out updates one clock after count_enable; rollover_flag is combinational on count_out.
// Backpressure: none; clear has priority over count_enable.
//
// Ports:
//   clk, n_rst      clock, asynchronous active-low reset (count -> 0)
//   clear           synchronous clear to 0
//   count_enable    advance the count this cycle
//   rollover_val    terminal count
//   count_out       current count
//   rollover_flag   high while count_out equals rollover_val
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            // Wrap to 1 rather than 0 so a full period is exactly rollover_val clocks.
            if (count_out == rollover_val) begin
                count_out <= NUM_CNT_BITS'(1);
            end else begin
                count_out <= count_out + 1'b1;
            end
        end
    end

    assign rollover_flag = (count_out == rollover_val);

endmodule

// File: rtl/rx_bit_sequencer.sv
// Serial receive control FSM: start-bit detect/validate, data-bit sample timing, stop-bit check.
// Latency: edge 0 = start detect; strobes after edges H+n*P; packet_done/framing_error after edge H+(D+1)*P.
// Backpressure: none; shift_strobe and packet_done are fire-and-forget single-cycle pulses.
//
// Ports:
//   clk    system clock, rising edge
//   n_rst  asynchronous active-low reset
//   bus    slave side of rx_bit_sequencer_if (line/timing in, status/strobes out)
module rx_bit_sequencer #(
    parameter int NUM_CNT_BITS = 4,
    parameter int BIT_CNT_BITS = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    rx_bit_sequencer_if.slave   bus
);
    import rx_seq_pkg::*;

    rx_state_t               state;
    rx_state_t               next_state;
    logic                    serial_prev;
    logic [NUM_CNT_BITS-1:0] p_lat;
    logic [BIT_CNT_BITS-1:0] d_lat;
    logic [NUM_CNT_BITS-1:0] p_in;
    logic [BIT_CNT_BITS-1:0] d_in;
    logic [NUM_CNT_BITS-1:0] half_m1;
    logic [NUM_CNT_BITS-1:0] period_m1;

    logic                    clk_clear;
    logic                    clk_en;
    logic [NUM_CNT_BITS-1:0] clk_count;
    logic                    clk_roll;
    logic                    bit_clear;
    logic                    bit_en;
    logic [BIT_CNT_BITS-1:0] bit_count_unused;
    logic                    bit_roll;

    logic                    start_edge;
    logic                    stop_hit;
    logic                    packet_done_q;
    logic                    framing_error_q;

    // Out-of-range timing requests are raised to the minimum legal value.
    assign p_in = (bus.bit_period < NUM_CNT_BITS'(MIN_BIT_PERIOD)) ?
                  NUM_CNT_BITS'(MIN_BIT_PERIOD) : bus.bit_period;
    assign d_in = (bus.data_bits < BIT_CNT_BITS'(MIN_DATA_BITS)) ?
                  BIT_CNT_BITS'(MIN_DATA_BITS) : bus.data_bits;

    // Decisions are taken on the edge where the counter reaches the target,
    // i.e. while it still shows target-1.
    assign half_m1   = (p_lat >> 1) - 1'b1;
    assign period_m1 = p_lat - 1'b1;

    assign start_edge = (state == IDLE) && serial_prev && !bus.serial_in;
    assign stop_hit   = (state == STOP_CHK) && (clk_count == period_m1);

    flex_counter #(.NUM_CNT_BITS(NUM_CNT_BITS)) u_clk_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (clk_clear),
        .count_enable  (clk_en),
        .rollover_val  (p_lat),
        .count_out     (clk_count),
        .rollover_flag (clk_roll)
    );

    flex_counter #(.NUM_CNT_BITS(BIT_CNT_BITS)) u_bit_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (bit_clear),
        .count_enable  (bit_en),
        .rollover_val  (d_lat),
        .count_out     (bit_count_unused),
        .rollover_flag (bit_roll)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        clk_clear  = 1'b0;
        clk_en     = 1'b0;
        bit_clear  = 1'b0;
        bit_en     = 1'b0;
        case (state)
            IDLE: begin
                // Holding both counters clear means edge 0 starts from zero.
                clk_clear = 1'b1;
                bit_clear = 1'b1;
                if (start_edge) begin
                    next_state = START_CHK;
                end
            end
            START_CHK: begin
                clk_en = 1'b1;
                if (clk_count == half_m1) begin
                    if (!bus.serial_in) begin
                        next_state = RECEIVE;
                        clk_clear  = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            RECEIVE: begin
                clk_en = 1'b1;
                bit_en = clk_roll;
                // The bit counter shows D one cycle after the last data strobe;
                // the clock counter keeps running so stop timing is unaffected.
                if (bit_roll) begin
                    next_state = STOP_CHK;
                end
            end
            STOP_CHK: begin
                clk_en = 1'b1;
                if (stop_hit) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            serial_prev     <= 1'b1;
            p_lat           <= '0;
            d_lat           <= '0;
            packet_done_q   <= 1'b0;
            framing_error_q <= 1'b0;
        end else begin
            serial_prev   <= bus.serial_in;
            packet_done_q <= stop_hit && bus.serial_in;
            if (start_edge) begin
                p_lat           <= p_in;
                d_lat           <= d_in;
                framing_error_q <= 1'b0;
            end else if (stop_hit && !bus.serial_in) begin
                framing_error_q <= 1'b1;
            end
        end
    end

    assign bus.busy          = (state != IDLE);
    assign bus.shift_strobe  = (state == RECEIVE) && clk_roll;
    assign bus.packet_done   = packet_done_q;
    assign bus.framing_error = framing_error_q;

endmodule

// File: tb/tb_rx_bit_sequencer.sv
// Directed bench for rx_bit_sequencer: drives edge-indexed line patterns and checks pulse timing.
// Latency: n/a.
// Backpressure: n/a.
module tb_rx_bit_sequencer;

    logic clk;
    logic n_rst;

    rx_bit_sequencer_if #(.NUM_CNT_BITS(4), .BIT_CNT_BITS(4)) bus ();

    rx_bit_sequencer #(.NUM_CNT_BITS(4), .BIT_CNT_BITS(4)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Line value to present at each edge, edge 0 = first start-bit edge.
    bit line_q[$];

    // Observations from the last run_line call (edge index = edge before the cycle).
    int          strobe_q[$];
    int          done_q[$];
    logic [15:0] cap;
    int          ncap;
    int          busy_rise;
    int          busy_fall;
    int          fe_first;
    int          fe_low_first;
    int          both_cnt;

    function automatic bit line_at(input int i);
        if (i >= 0 && i < line_q.size()) return line_q[i];
        return 1'b1;
    endfunction

    task automatic push_bits(input bit v, input int n);
        for (int i = 0; i < n; i++) line_q.push_back(v);
    endtask

    task automatic push_frame(input int p, input int d, input logic [15:0] data,
                              input bit stop, input int stop_len);
        push_bits(1'b0, p);
        for (int n = 0; n < d; n++) push_bits(data[n], p);
        push_bits(stop, stop_len);
    endtask

    task automatic idle(input int n);
        bus.serial_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Plays line_q for edges 0..n_cycles and records what the DUT does.
    task automatic run_line(input int n_cycles, input int chg_edge, input logic [3:0] chg_p);
        bit was_busy;
        strobe_q.delete();
        done_q.delete();
        cap          = '0;
        ncap         = 0;
        busy_rise    = -1;
        busy_fall    = -1;
        fe_first     = -1;
        fe_low_first = -1;
        both_cnt     = 0;
        was_busy     = 1'b0;
        bus.serial_in = line_at(0);
        for (int e = 0; e <= n_cycles; e++) begin
            @(posedge clk);
            #1;
            if (bus.shift_strobe) begin
                strobe_q.push_back(e);
                // The shift register takes the line at the edge ending the strobe cycle.
                if (ncap < 16) cap[ncap] = line_at(e + 1);
                ncap++;
            end
            if (bus.packet_done) done_q.push_back(e);
            if (bus.shift_strobe && bus.packet_done) both_cnt++;
            if (bus.busy && busy_rise < 0) busy_rise = e;
            if (was_busy && !bus.busy && busy_fall < 0) busy_fall = e;
            was_busy = bus.busy;
            if (bus.framing_error && fe_first < 0) fe_first = e;
            if (!bus.framing_error && fe_low_first < 0) fe_low_first = e;
            if (e + 1 == chg_edge) bus.bit_period = chg_p;
            bus.serial_in = line_at(e + 1);
        end
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        bus.serial_in  = 1'b1;
        bus.bit_period = 4'd10;
        bus.data_bits  = 4'd8;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
        checks++; if (bus.shift_strobe !== 1'b0) $display("FAIL reset_strobe: got %b want 0", bus.shift_strobe); else passed++;
        checks++; if (bus.packet_done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.packet_done); else passed++;
        checks++; if (bus.framing_error !== 1'b0) $display("FAIL reset_ferr: got %b want 0", bus.framing_error); else passed++;
        checks++; if (dut.state !== rx_seq_pkg::IDLE) $display("FAIL reset_state: got %0d want %0d", dut.state, rx_seq_pkg::IDLE); else passed++;
        checks++; if (dut.serial_prev !== 1'b1) $display("FAIL reset_serial_prev: got %b want 1", dut.serial_prev); else passed++;
        n_rst = 1'b1;
        idle(4);
        checks++; if (bus.busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", bus.busy); else passed++;
    endtask

    task automatic test_basic;
        bus.bit_period = 4'd10;
        bus.data_bits  = 4'd8;
        line_q.delete();
        push_frame(10, 8, 16'h005A, 1'b1, 10);
        run_line(110, -1, 4'd0);
        checks++; if (strobe_q.size() !== 8) $display("FAIL basic_strobe_cnt: got %0d want 8", strobe_q.size()); else passed++;
        for (int k = 0; k < 8; k++) begin
            if (k < strobe_q.size()) begin
                checks++;
                if (strobe_q[k] !== 15 + 10 * k) $display("FAIL basic_strobe_%0d: got edge %0d want %0d", k, strobe_q[k], 15 + 10 * k);
                else passed++;
            end
        end
        checks++; if (cap[7:0] !== 8'h5A) $display("FAIL basic_data: got %h want 5a", cap[7:0]); else passed++;
        checks++; if (done_q.size() !== 1) $display("FAIL basic_done_cnt: got %0d want 1", done_q.size()); else passed++;
        checks++; if (done_q.size() > 0 && done_q[0] !== 95) $display("FAIL basic_done_edge: got %0d want 95", done_q[0]); else passed++;
        checks++; if (fe_first !== -1) $display("FAIL basic_ferr: got first set edge %0d want none", fe_first); else passed++;
        checks++; if (busy_rise !== 0) $display("FAIL basic_busy_rise: got %0d want 0", busy_rise); else passed++;
        checks++; if (busy_fall !== 95) $display("FAIL basic_busy_fall: got %0d want 95", busy_fall); else passed++;
        checks++; if (both_cnt !== 0) $display("FAIL basic_overlap: got %0d want 0", both_cnt); else passed++;
    endtask

    task automatic test_glitch;
        idle(3);
        bus.bit_period = 4'd10;
        bus.data_bits  = 4'd8;
        line_q.delete();
        push_bits(1'b0, 3);
        run_line(30, -1, 4'd0);
        checks++; if (strobe_q.size() !== 0) $display("FAIL glitch_strobe: got %0d want 0", strobe_q.size()); else passed++;
        checks++; if (done_q.size() !== 0) $display("FAIL glitch_done: got %0d want 0", done_q.size()); else passed++;
        checks++; if (busy_rise !== 0) $display("FAIL glitch_busy_rise: got %0d want 0", busy_rise); else passed++;
        checks++; if (busy_fall !== 5) $display("FAIL glitch_busy_fall: got %0d want 5", busy_fall); else passed++;
    endtask

    task automatic test_framing;
        idle(3);
        bus.bit_period = 4'd10;
        bus.data_bits  = 4'd8;
        line_q.delete();
        push_frame(10, 8, 16'h00C3, 1'b0, 10);
        run_line(110, -1, 4'd0);
        checks++; if (done_q.size() !== 0) $display("FAIL ferr_done: got %0d want 0", done_q.size()); else passed++;
        checks++; if (fe_first !== 95) $display("FAIL ferr_set_edge: got %0d want 95", fe_first); else passed++;
        checks++; if (strobe_q.size() !== 8) $display("FAIL ferr_strobe_cnt: got %0d want 8", strobe_q.size()); else passed++;
        idle(5);
        checks++; if (bus.framing_error !== 1'b1) $display("FAIL ferr_sticky: got %b want 1", bus.framing_error); else passed++;
        line_q.delete();
        push_frame(10, 8, 16'h0011, 1'b1, 10);
        run_line(110, -1, 4'd0);
        checks++; if (fe_low_first !== 0) $display("FAIL ferr_clear_edge: got %0d want 0", fe_low_first); else passed++;
        checks++; if (done_q.size() !== 1 || done_q[0] !== 95) $display("FAIL ferr_next_done: got cnt %0d want 1 at 95", done_q.size()); else passed++;
        checks++; if (cap[7:0] !== 8'h11) $display("FAIL ferr_next_data: got %h want 11", cap[7:0]); else passed++;
    endtask

    task automatic test_back_to_back;
        idle(3);
        bus.bit_period = 4'd10;
        bus.data_bits  = 4'd8;
        line_q.delete();
        // Stop held only through the sample edge 95; next start at edge 96.
        push_frame(10, 8, 16'h00A5, 1'b1, 6);
        push_frame(10, 8, 16'h003C, 1'b1, 10);
        run_line(200, -1, 4'd0);
        checks++; if (done_q.size() !== 2) $display("FAIL b2b_done_cnt: got %0d want 2", done_q.size()); else passed++;
        checks++; if (done_q.size() > 0 && done_q[0] !== 95) $display("FAIL b2b_done0: got %0d want 95", done_q[0]); else passed++;
        checks++; if (done_q.size() > 1 && done_q[1] !== 191) $display("FAIL b2b_done1: got %0d want 191", done_q[1]); else passed++;
        checks++; if (strobe_q.size() !== 16) $display("FAIL b2b_strobe_cnt: got %0d want 16", strobe_q.size()); else passed++;
        checks++; if (strobe_q.size() > 8 && strobe_q[8] !== 111) $display("FAIL b2b_strobe8: got %0d want 111", strobe_q[8]); else passed++;
        checks++; if (cap !== 16'h3CA5) $display("FAIL b2b_data: got %h want 3ca5", cap); else passed++;
        checks++; if (busy_fall !== 95) $display("FAIL b2b_busy_fall: got %0d want 95", busy_fall); else passed++;
        checks++; if (both_cnt !== 0) $display("FAIL b2b_overlap: got %0d want 0", both_cnt); else passed++;
    endtask

    task automatic test_latched_params;
        idle(3);
        bus.bit_period = 4'd5;
        bus.data_bits  = 4'd3;
        line_q.delete();
        push_frame(5, 3, 16'h0005, 1'b1, 5);
        run_line(40, 8, 4'd12);
        checks++; if (strobe_q.size() !== 3) $display("FAIL latch_strobe_cnt: got %0d want 3", strobe_q.size()); else passed++;
        for (int k = 0; k < 3; k++) begin
            if (k < strobe_q.size()) begin
                checks++;
                if (strobe_q[k] !== 7 + 5 * k) $display("FAIL latch_strobe_%0d: got edge %0d want %0d", k, strobe_q[k], 7 + 5 * k);
                else passed++;
            end
        end
        checks++; if (done_q.size() !== 1 || done_q[0] !== 22) $display("FAIL latch_done: got cnt %0d want 1 at 22", done_q.size()); else passed++;
        checks++; if (cap[2:0] !== 3'b101) $display("FAIL latch_data: got %b want 101", cap[2:0]); else passed++;
    endtask

    task automatic test_reset_mid;
        idle(3);
        bus.bit_period = 4'd10;
        bus.data_bits  = 4'd8;
        line_q.delete();
        push_frame(10, 8, 16'h00FF, 1'b1, 10);
        run_line(40, -1, 4'd0);
        n_rst = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", bus.busy); else passed++;
        checks++; if (bus.shift_strobe !== 1'b0) $display("FAIL mid_rst_strobe: got %b want 0", bus.shift_strobe); else passed++;
        checks++; if (bus.packet_done !== 1'b0) $display("FAIL mid_rst_done: got %b want 0", bus.packet_done); else passed++;
        checks++; if (dut.state !== rx_seq_pkg::IDLE) $display("FAIL mid_rst_state: got %0d want %0d", dut.state, rx_seq_pkg::IDLE); else passed++;
        #1;
        n_rst = 1'b1;
        idle(5);
        line_q.delete();
        push_frame(10, 8, 16'h0096, 1'b1, 10);
        run_line(110, -1, 4'd0);
        checks++; if (done_q.size() !== 1 || done_q[0] !== 95) $display("FAIL mid_rst_next_done: got cnt %0d want 1 at 95", done_q.size()); else passed++;
        checks++; if (cap[7:0] !== 8'h96) $display("FAIL mid_rst_next_data: got %h want 96", cap[7:0]); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_latched_params();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
